// File: rtl/mig_seq_pkg.sv
// mig_seq_pkg: MIG command codes, sequencer states and beat-count derivation.
package mig_seq_pkg;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ_CMD, S_READ_WAIT} state_t;
    function automatic int line_beats(input int line_w, input int ui_w);
        return line_w / ui_w;
    endfunction
endpackage

// File: rtl/line_beat_buf.sv
// line_beat_buf: line register loaded whole or one beat at a time, read whole or one beat at a time.
module line_beat_buf #(
    parameter int LINE_W = 768,
    parameter int UI_W   = 256,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [UI_W-1:0]   beat_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [LINE_W-1:0] line_o,
    output logic [UI_W-1:0]   beat_o
);
    logic [LINE_W-1:0] line_q;
    always_ff @(posedge clk) begin
        if (reset) line_q <= '0;
        else if (load_i) line_q <= line_i;
        else if (wr_en_i) line_q[int'(wr_idx_i)*UI_W +: UI_W] <= beat_i;
    end
    assign line_o = line_q;
    assign beat_o = line_q[int'(rd_idx_i)*UI_W +: UI_W];
endmodule

// File: rtl/mig_line_sequencer.sv
// mig_line_sequencer: splits line writes/reads into BL8 MIG commands and reassembles read lines.
// Define MIG_SEQ_WATCHDOG_EN to abort a READ_WAIT that lasts RD_TIMEOUT cycles.
module mig_line_sequencer
    import mig_seq_pkg::*;
#(
    parameter int ADDR_W     = 31,
    parameter int LINE_W     = 768,
    parameter int UI_W       = 256,
    parameter int ADDR_STEP  = 8,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phy_init_done,
    input  logic              write_in,
    input  logic [ADDR_W-1:0] w_address_in,
    input  logic [LINE_W-1:0] w_data_in,
    output logic              w_busy,
    input  logic              read_in,
    input  logic [ADDR_W-1:0] r_address_in,
    output logic              r_busy,
    output logic [LINE_W-1:0] r_data_out,
    output logic              r_valid_out,
    output logic              rd_timeout,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [UI_W-1:0]   app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [UI_W/8-1:0] app_wdf_mask,
    input  logic              app_wdf_rdy,
    input  logic [UI_W-1:0]   app_rd_data,
    input  logic              app_rd_data_valid
);
    localparam int BEATS = line_beats(LINE_W, UI_W);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] DONE = CNT_W'(BEATS);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d, wdf_cnt_q, wdf_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] w_addr_q, r_addr_q;
    logic [LINE_W-1:0] r_data_q, rd_line, line_out;
    logic [UI_W-1:0] beat_out;
    logic rd_pend_q, rd_pend_d, r_valid_q;
    logic wr_acc, rd_acc, rd_beat, rd_last, timeout;
    assign w_busy       = state_q != S_IDLE;
    assign r_busy       = state_q != S_IDLE;
    assign wr_acc       = write_in & ~w_busy;
    assign rd_acc       = read_in & ~r_busy;
    assign rd_beat      = app_rd_data_valid & (state_q == S_READ_CMD || state_q == S_READ_WAIT);
    assign rd_last      = rd_beat & (rd_cnt_q == LAST);
    assign app_en       = (state_q == S_WRITE || state_q == S_READ_CMD) && cmd_cnt_q != DONE;
    assign app_cmd      = state_q == S_READ_CMD ? CMD_READ : CMD_WRITE;
    assign app_addr     = app_en ? (state_q == S_WRITE ? w_addr_q : r_addr_q) + ADDR_W'(int'(cmd_cnt_q) * ADDR_STEP) : '0;
    assign app_wdf_wren = state_q == S_WRITE && wdf_cnt_q != DONE;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = app_wdf_wren ? beat_out : '0;
    assign app_wdf_mask = '0;
    assign r_valid_out  = r_valid_q;
    assign r_data_out   = r_data_q;
    // Write data is unpacked and read data packed through the same buffer; they never overlap.
    line_beat_buf #(.LINE_W(LINE_W), .UI_W(UI_W), .IDX_W(CNT_W)) u_buf (
        .clk(clk), .reset(reset), .load_i(wr_acc), .line_i(w_data_in),
        .wr_en_i(rd_beat), .wr_idx_i(rd_cnt_q), .beat_i(app_rd_data),
        .rd_idx_i(wdf_cnt_q), .line_o(line_out), .beat_o(beat_out)
    );
    always_comb begin
        rd_line = line_out;
        rd_line[(BEATS-1)*UI_W +: UI_W] = app_rd_data;
    end
    always_comb begin
        state_d   = state_q;
        rd_pend_d = rd_pend_q;
        cmd_cnt_d = cmd_cnt_q + CNT_W'(app_en & app_rdy);
        wdf_cnt_d = wdf_cnt_q + CNT_W'(app_wdf_wren & app_wdf_rdy);
        rd_cnt_d  = rd_last ? '0 : rd_cnt_q + CNT_W'(rd_beat);
        case (state_q)
            S_INIT: state_d = phy_init_done ? S_IDLE : S_INIT;
            S_IDLE: begin
                state_d   = wr_acc ? S_WRITE : rd_acc ? S_READ_CMD : S_IDLE;
                rd_pend_d = wr_acc & rd_acc;
            end
            S_WRITE: if (cmd_cnt_d == DONE && wdf_cnt_d == DONE) begin
                state_d   = rd_pend_q ? S_READ_CMD : S_IDLE;
                rd_pend_d = 1'b0;
                cmd_cnt_d = '0;
                wdf_cnt_d = '0;
            end
            S_READ_CMD: if (cmd_cnt_d == DONE) begin
                state_d   = S_READ_WAIT;
                cmd_cnt_d = '0;
            end
            S_READ_WAIT: if (rd_last || timeout) begin
                state_d  = S_IDLE;
                rd_cnt_d = '0;
            end
            default: state_d = S_INIT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_INIT;
            cmd_cnt_q <= '0;
            wdf_cnt_q <= '0;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            w_addr_q  <= '0;
            r_addr_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_cnt_q <= cmd_cnt_d;
            wdf_cnt_q <= wdf_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_pend_q <= rd_pend_d;
            w_addr_q  <= wr_acc ? w_address_in : w_addr_q;
            r_addr_q  <= rd_acc ? r_address_in : r_addr_q;
            r_valid_q <= rd_last;
            r_data_q  <= rd_last ? rd_line : r_data_q;
        end
    end
`ifdef MIG_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(RD_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic rd_timeout_q;
    // A final beat arriving on the limit cycle still completes the read.
    assign timeout    = state_q == S_READ_WAIT && wd_cnt_q == WD_W'(RD_TIMEOUT - 1) && !rd_last;
    assign rd_timeout = rd_timeout_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q     <= '0;
            rd_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q     <= state_q == S_READ_WAIT ? wd_cnt_q + 1'b1 : '0;
            rd_timeout_q <= timeout;
        end
    end
`else
    assign timeout    = 1'b0;
    assign rd_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_mig_line_sequencer.sv
// tb_mig_line_sequencer: directed bench with a transaction-level model of the expected MIG traffic.
module tb_mig_line_sequencer;
    localparam int AW = 31, LW = 768, UW = 256, RD_TO = 1023;
    logic clk = 0, reset = 1, phy_init_done = 0, write_in = 0, read_in = 0;
    logic app_rdy = 1, app_wdf_rdy = 1, app_rd_data_valid = 0;
    logic [AW-1:0] w_address_in = '0, r_address_in = '0, app_addr;
    logic [LW-1:0] w_data_in = '0, r_data_out;
    logic w_busy, r_busy, r_valid_out, rd_timeout, app_en, app_wdf_wren, app_wdf_end;
    logic [2:0] app_cmd;
    logic [UW-1:0] app_wdf_data, app_rd_data = '0;
    logic [UW/8-1:0] app_wdf_mask;
    int checks = 0, errors = 0, rsp_budget = 1 << 30;
    bit rand_rdy = 0, stray = 0;
    logic [33:0] exp_cmd[$];
    logic [UW-1:0] exp_beat[$];
    logic [LW-1:0] exp_line[$];
    logic [AW-1:0] rsp_q[$];

    always #5 clk = ~clk;

    mig_line_sequencer dut (
        .clk(clk), .reset(reset), .phy_init_done(phy_init_done),
        .write_in(write_in), .w_address_in(w_address_in), .w_data_in(w_data_in), .w_busy(w_busy),
        .read_in(read_in), .r_address_in(r_address_in), .r_busy(r_busy),
        .r_data_out(r_data_out), .r_valid_out(r_valid_out), .rd_timeout(rd_timeout),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    function automatic logic [UW-1:0] beat_of(input logic [AW-1:0] a);
        return {8{{1'b0, a} ^ 32'h5A5A_C3C3}};
    endfunction
    function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] base, input int k);
        return base + AW'(k * 8);
    endfunction
    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_write(input logic [AW-1:0] a, input logic [LW-1:0] d);
        for (int k = 0; k < 3; k++) begin
            exp_cmd.push_back({3'b000, line_addr(a, k)});
            exp_beat.push_back(d[k*UW +: UW]);
        end
    endtask
    task automatic expect_read(input logic [AW-1:0] a, input bit completes);
        for (int k = 0; k < 3; k++) exp_cmd.push_back({3'b001, line_addr(a, k)});
        if (completes) exp_line.push_back({beat_of(line_addr(a, 2)), beat_of(line_addr(a, 1)), beat_of(a)});
    endtask
    task automatic issue(input bit wr, input bit rd, input logic [AW-1:0] wa, input logic [LW-1:0] wd, input logic [AW-1:0] ra);
        w_address_in = wa;
        w_data_in = wd;
        r_address_in = ra;
        write_in = wr;
        read_in = rd;
        step();
        write_in = 0;
        read_in = 0;
    endtask
    task automatic wait_idle(input int bound);
        int n = 0;
        while ((w_busy || r_busy) && n < bound) begin
            step();
            n++;
        end
        if (w_busy || r_busy) fail("wait_idle", "still busy after cycle bound");
    endtask
    task automatic wait_rvalid(input int bound, input string name);
        int n = 0;
        while (!r_valid_out && n < bound) begin
            chk({name, "_rbusy_held"}, r_busy, 1);
            step();
            n++;
        end
        if (!r_valid_out) fail({name, "_rvalid"}, "r_valid_out never rose");
        else chk({name, "_rbusy_clear"}, r_busy, 0);
    endtask

    // Ready generator: tied high unless random stalling is enabled.
    initial forever begin
        @(posedge clk);
        #1;
        app_rdy = !rand_rdy || $urandom_range(0, 2) != 0;
        app_wdf_rdy = !rand_rdy || $urandom_range(0, 2) != 0;
    end

    // MIG read responder: returns one beat per accepted read command, in order.
    initial forever begin
        @(posedge clk);
        #1;
        if (reset || rsp_budget == 0) rsp_q.delete();
        if (stray) begin
            app_rd_data_valid = 1;
            app_rd_data = {8{32'hDEAD_BEEF}};
        end else if (rsp_q.size() != 0 && (!rand_rdy || $urandom_range(0, 1) == 1)) begin
            app_rd_data_valid = 1;
            app_rd_data = beat_of(rsp_q.pop_front());
            rsp_budget--;
        end else begin
            app_rd_data_valid = 0;
            app_rd_data = '0;
        end
    end

    // Compare process: every accepted command/beat/line against the model queues.
    logic p_en = 0, p_rdy = 0, p_wr = 0, p_wrdy = 0, p_rv = 0;
    logic [AW-1:0] p_addr;
    logic [2:0] p_cmd;
    logic [UW-1:0] p_data;
    always @(negedge clk) begin
        if (reset) begin
            p_en = 0;
            p_wr = 0;
            p_rv = 0;
        end else begin
            if (p_en && !p_rdy) begin
                if (!app_en) fail("cmd_hold", "command withdrawn while stalled");
                else begin
                    chk("cmd_hold_addr", app_addr, p_addr);
                    chk("cmd_hold_cmd", app_cmd, p_cmd);
                end
            end
            if (app_en && app_rdy) begin
                if (exp_cmd.size() == 0) fail("cmd_extra", $sformatf("unexpected cmd %0h addr %0h", app_cmd, app_addr));
                else chk("cmd", {app_cmd, app_addr}, exp_cmd.pop_front());
                if (app_cmd == 3'b001) rsp_q.push_back(app_addr);
            end
            if (p_wr && !p_wrdy) begin
                if (!app_wdf_wren) fail("wdf_hold", "beat withdrawn while stalled");
                else chk("wdf_hold_data", app_wdf_data, p_data);
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                chk("wdf_end", app_wdf_end, 1);
                if (exp_beat.size() == 0) fail("wdf_extra", $sformatf("unexpected beat %0h", app_wdf_data));
                else chk("wdf_data", app_wdf_data, exp_beat.pop_front());
            end
            chk("wdf_mask", app_wdf_mask, 0);
`ifndef MIG_SEQ_WATCHDOG_EN
            chk("rd_timeout_tied", rd_timeout, 0);
`endif
            if (r_valid_out) begin
                if (p_rv) fail("rvalid_pulse", "r_valid_out high for two cycles");
                if (exp_line.size() == 0) fail("rvalid_extra", $sformatf("unexpected line %0h", r_data_out));
                else chk("r_data", r_data_out, exp_line.pop_front());
            end
            p_en = app_en;
            p_rdy = app_rdy;
            p_addr = app_addr;
            p_cmd = app_cmd;
            p_wr = app_wdf_wren;
            p_wrdy = app_wdf_rdy;
            p_data = app_wdf_data;
            p_rv = r_valid_out;
        end
    end

    initial begin
        logic [UW-1:0] a_b, b_b, c_b;
        logic [LW-1:0] held;
        a_b = {8{32'hA0A0_0001}};
        b_b = {8{32'hB0B0_0002}};
        c_b = {8{32'hC0C0_0003}};
        repeat (3) step();
        chk("rst_busy", {w_busy, r_busy}, 2'b11);
        chk("rst_cmd", {app_en, app_wdf_wren, app_addr}, 0);
        chk("rst_read", {r_valid_out, rd_timeout, r_data_out}, 0);
        reset = 0;
        issue(1, 1, 31'h40, rand_line(), 31'h80);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("init_busy", {w_busy, r_busy}, 2'b11);
            chk("init_app_en", app_en, 0);
        end
        phy_init_done = 1;
        step();
        chk("init_done_busy", {w_busy, r_busy}, 2'b00);

        expect_write(31'h100, {a_b, b_b, c_b});
        issue(1, 0, 31'h100, {a_b, b_b, c_b}, '0);
        chk("wr_t1", {app_en, app_wdf_wren, w_busy, app_addr}, {3'b111, 31'h100});
        chk("wr_t1_data", app_wdf_data, c_b);
        issue(1, 0, 31'h999, rand_line(), '0);
        chk("wr_t2", {app_en, app_addr}, {1'b1, 31'h108});
        chk("wr_t2_data", app_wdf_data, b_b);
        step();
        chk("wr_t3", {app_en, w_busy, app_addr}, {2'b11, 31'h110});
        chk("wr_t3_data", app_wdf_data, a_b);
        step();
        chk("wr_t4", {app_en, app_wdf_wren, w_busy}, 3'b000);

        held = rand_line();
        expect_write(31'h2000, held);
        expect_read(31'h3000, 1);
        issue(1, 1, 31'h2000, held, 31'h3000);
        chk("sim_t1", {app_cmd, app_addr}, {3'b000, 31'h2000});
        repeat (3) step();
        chk("sim_t4", {app_cmd, app_addr, r_busy}, {3'b001, 31'h3000, 1'b1});
        wait_rvalid(40, "sim");

        rand_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] wa, ra;
            wa = AW'($urandom);
            ra = AW'($urandom);
            held = rand_line();
            expect_write(wa, held);
            expect_read(ra, 1);
            if (i % 2 == 1) issue(1, 1, wa, held, ra);
            else begin
                issue(1, 0, wa, held, '0);
                wait_idle(200);
                issue(0, 1, '0, '0, ra);
            end
            wait_idle(200);
        end
        rand_rdy = 0;
        step();

        stray = 1;
        repeat (2) step();
        stray = 0;
        repeat (2) step();
        expect_read(31'h7FFF_FFF8, 1);
        issue(0, 1, '0, '0, 31'h7FFF_FFF8);
        chk("wrap_t1", {app_en, app_cmd, app_addr}, {1'b1, 3'b001, 31'h7FFF_FFF8});
        step();
        chk("wrap_t2", app_addr, 31'h0);
        step();
        chk("wrap_t3", app_addr, 31'h8);
        wait_rvalid(40, "wrap");
        chk("wrap_line", r_data_out, {{8{32'h5A5A_C3CB}}, {8{32'h5A5A_C3C3}}, {8{32'h25A5_3C3B}}});
        held = r_data_out;
        step();
        chk("wrap_pulse_end", r_valid_out, 0);
        chk("wrap_hold", r_data_out, held);

        rsp_budget = 2;
        expect_read(31'h500, 0);
        issue(0, 1, '0, '0, 31'h500);
`ifdef MIG_SEQ_WATCHDOG_EN
        begin
            int n = 0;
            while (!rd_timeout && n < RD_TO + 50) begin
                step();
                n++;
            end
            if (!rd_timeout) fail("wd_pulse", "rd_timeout never pulsed");
            else chk("wd_rbusy", r_busy, 0);
            step();
            chk("wd_pulse_end", rd_timeout, 0);
        end
`else
        repeat (60) step();
        chk("stall_rbusy", {r_busy, app_en, r_valid_out}, 3'b100);
        reset = 1;
        step();
        chk("midrst_busy", {w_busy, r_busy, app_en}, 3'b110);
        reset = 0;
        step();
        chk("midrst_idle", {w_busy, r_busy}, 2'b00);
`endif
        rsp_budget = 1 << 30;
        expect_read(31'h1230, 1);
        issue(0, 1, '0, '0, 31'h1230);
        wait_idle(50);
        repeat (3) step();
        chk("left_cmds", exp_cmd.size(), 0);
        chk("left_beats", exp_beat.size(), 0);
        chk("left_lines", exp_line.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
